// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder and its benches.
// The optional RCA_SIGNED_OVF_EN build adds a registered signed-overflow output.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;
  localparam int RCA_MAX_WIDTH     = 64;

  // Raw {carry, sum} result wide enough for the largest legal WIDTH.
  typedef logic [RCA_MAX_WIDTH:0] rca_raw_t;

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full-adder cell; WIDTH copies are chained to form the ripple adder.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_adder.sv
// Registered ripple-carry adder: {carry, sum} <= a + b + cin one cycle after in_valid.
// Define RCA_SIGNED_OVF_EN to add the registered two's-complement overflow output.
module rca_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef RCA_SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_n;

  assign c[0] = cin;

  // Carry ripples bit-serially from cell i into cell i+1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum_n[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_n;
        carry <= c[WIDTH];
      end
    end
  end

`ifdef RCA_SIGNED_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_rca_adder.sv
// Scoreboard bench for rca_adder at WIDTH=4 (directed + exhaustive) and WIDTH=16 (random).
// Build with RCA_SIGNED_OVF_EN defined to also check the overflow output.
module tb_rca_adder;
  import rca_pkg::*;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       c;
    logic       o;
  } vec4_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ov4, c4;
  logic [3:0]  s4;

  logic        v16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ov16, c16;
  logic [15:0] s16;

`ifdef RCA_SIGNED_OVF_EN
  logic of4, of16;
`endif

  int tests = 0;
  int fails = 0;
  exp_t q4[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  rca_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .sum(s4), .carry(c4)
`ifdef RCA_SIGNED_OVF_EN
    , .overflow(of4)
`endif
  );

  rca_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .sum(s16), .carry(c16)
`ifdef RCA_SIGNED_OVF_EN
    , .overflow(of16)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per presented result.
  always @(negedge clk) begin
    if (ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("w4_unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4_sum", {60'd0, s4}, {48'd0, e.sum});
        check("w4_carry", {63'd0, c4}, {63'd0, e.carry});
`ifdef RCA_SIGNED_OVF_EN
        check("w4_overflow", {63'd0, of4}, {63'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov16 === 1'b1) begin
      if (q16.size() == 0) begin
        check("w16_unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("w16_sum", {48'd0, s16}, {48'd0, e.sum});
        check("w16_carry", {63'd0, c16}, {63'd0, e.carry});
`ifdef RCA_SIGNED_OVF_EN
        check("w16_overflow", {63'd0, of16}, {63'd0, e.ovf});
`endif
      end
    end
  end

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic push, input exp_t e);
    @(posedge clk);
    #1;
    v4 = v; a4 = a; b4 = b; cin4 = ci;
    if (push) q4.push_back(e);
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic push, input exp_t e);
    @(posedge clk);
    #1;
    v16 = v; a16 = a; b16 = b; cin16 = ci;
    if (push) q16.push_back(e);
  endtask

  // Model for generated vectors; signed overflow uses the sign-bit rule.
  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    rca_raw_t r;
    exp_t e;
    r = rca_raw_t'(a) + rca_raw_t'(b) + rca_raw_t'(ci);
    e.sum   = {12'd0, r[3:0]};
    e.carry = r[4];
    e.ovf   = (a[3] == b[3]) && (r[3] != a[3]);
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    rca_raw_t r;
    exp_t e;
    r = rca_raw_t'(a) + rca_raw_t'(b) + rca_raw_t'(ci);
    e.sum   = r[15:0];
    e.carry = r[16];
    e.ovf   = (a[15] == b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  task automatic wait_drain();
    for (int k = 0; k < 50 && (q4.size() != 0 || q16.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    check("w4_queue_drained", 64'(q4.size()), 64'd0);
    check("w16_queue_drained", 64'(q16.size()), 64'd0);
  endtask

  initial begin
    vec4_t dir4[6];
    exp_t  e;
    exp_t  none;
    none = '{sum: 16'd0, carry: 1'b0, ovf: 1'b0};

    dir4[0] = '{a: 4'b0001, b: 4'b0001, cin: 1'b0, s: 4'b0010, c: 1'b0, o: 1'b0};
    dir4[1] = '{a: 4'b0010, b: 4'b0001, cin: 1'b0, s: 4'b0011, c: 1'b0, o: 1'b0};
    dir4[2] = '{a: 4'b1000, b: 4'b0000, cin: 1'b0, s: 4'b1000, c: 1'b0, o: 1'b0};
    dir4[3] = '{a: 4'b1111, b: 4'b0001, cin: 1'b0, s: 4'b0000, c: 1'b1, o: 1'b0};
    dir4[4] = '{a: 4'b1111, b: 4'b1111, cin: 1'b1, s: 4'b1111, c: 1'b1, o: 1'b0};
    dir4[5] = '{a: 4'b0111, b: 4'b0000, cin: 1'b1, s: 4'b1000, c: 1'b0, o: 1'b1};

    // Reset state while rst is held from time zero.
    #2;
    check("rst_w4_out_valid", {63'd0, ov4}, 64'd0);
    check("rst_w4_sum", {60'd0, s4}, 64'd0);
    check("rst_w4_carry", {63'd0, c4}, 64'd0);
    check("rst_w16_out_valid", {63'd0, ov16}, 64'd0);
    check("rst_w16_sum", {48'd0, s16}, 64'd0);
    check("rst_w16_carry", {63'd0, c16}, 64'd0);
    #10 rst = 1'b0;

    // Directed vectors, back-to-back.
    foreach (dir4[i]) begin
      e = '{sum: {12'd0, dir4[i].s}, carry: dir4[i].c, ovf: dir4[i].o};
      drive4(1'b1, dir4[i].a, dir4[i].b, dir4[i].cin, 1'b1, e);
    end
    drive4(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, none);

    // Async reset mid-cycle after the last result was presented.
    #6;
    check("pre_rst_out_valid", {63'd0, ov4}, 64'd1);
    check("pre_rst_sum", {60'd0, s4}, 64'h8);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {63'd0, ov4}, 64'd0);
    check("async_rst_sum", {60'd0, s4}, 64'd0);
    check("async_rst_carry", {63'd0, c4}, 64'd0);
    v4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_out_valid", {63'd0, ov4}, 64'd0);
    check("rst_hold_sum", {60'd0, s4}, 64'd0);
    check("rst_hold_carry", {63'd0, c4}, 64'd0);
    #2;
    rst = 1'b0;
    v4  = 1'b0;

    // Valid gating: result held while in_valid is low.
    drive4(1'b1, 4'b0010, 4'b0001, 1'b0, 1'b1, '{sum: 16'h3, carry: 1'b0, ovf: 1'b0});
    drive4(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, none);
    @(posedge clk);
    @(negedge clk);
    check("gate_out_valid", {63'd0, ov4}, 64'd0);
    check("gate_sum_held", {60'd0, s4}, 64'h3);
    check("gate_carry_held", {63'd0, c4}, 64'd0);

    // Exhaustive WIDTH=4 sweep, back-to-back.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = 9'(i);
      drive4(1'b1, idx[3:0], idx[7:4], idx[8], 1'b1, model4(idx[3:0], idx[7:4], idx[8]));
    end
    drive4(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, none);

    // WIDTH=16 boundary vectors then random sweep.
    drive16(1'b1, 16'hffff, 16'hffff, 1'b1, 1'b1, '{sum: 16'hffff, carry: 1'b1, ovf: 1'b0});
    drive16(1'b1, 16'h7fff, 16'h0000, 1'b1, 1'b1, '{sum: 16'h8000, carry: 1'b0, ovf: 1'b1});
    drive16(1'b1, 16'hffff, 16'h0001, 1'b0, 1'b1, '{sum: 16'h0000, carry: 1'b1, ovf: 1'b0});
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      drive16(1'b1, ra, rb, rc, 1'b1, model16(ra, rb, rc));
    end
    drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, none);

    wait_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rca_adder.md
Name: rca_adder

Overview:
- Parameterised ripple-carry adder: adds two WIDTH-bit unsigned operands plus a carry-in.
- Produces a WIDTH-bit sum and a carry-out, captured in an output register.
- Used as a small arithmetic leaf in datapaths that need a simple, area-cheap adder with one-cycle registered latency.
- Carry propagates bit-serially through a chain of full-adder cells; no carry-lookahead.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum/carry hold a result computed from a valid input.
- sum  output  WIDTH  registered sum, bits WIDTH-1:0 of a+b+cin.
- carry  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Reset: rst high forces sum=0, carry=0, out_valid=0 immediately, independent of clk. Values are held while rst is high.
- Arithmetic:
  - The combinational chain computes {carry_n, sum_n} = a + b + cin as a (WIDTH+1)-bit unsigned result.
  - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])); c[0] = cin; carry_n = c[WIDTH].
- Latency:
  - On a rising clk edge with in_valid=1, sum<=sum_n, carry<=carry_n, out_valid<=1. The result is visible one cycle after the operands are presented.
  - On a rising clk edge with in_valid=0, out_valid<=0 and sum/carry hold their previous values.
- Throughput: one addition per cycle; back-to-back valid inputs produce back-to-back results. There is no backpressure.
- Wrap-around: overflow beyond WIDTH bits appears only in carry; sum wraps modulo 2^WIDTH. Example: 1111+0001+0 gives sum=0000, carry=1.
- Maximum value: all-ones + all-ones + 1 gives sum=all-ones, carry=1.
- Reset deasserted mid-stream: the first edge after release behaves normally. There is no sync-release stall requirement.
- Unknown inputs while in_valid=0 must not disturb the held outputs.

Optional Feature:
- Macro RCA_SIGNED_OVF_EN.
- When defined: an extra output port overflow (1 bit) is registered alongside sum.
  - overflow = c[WIDTH] ^ c[WIDTH-1], i.e. the two's-complement signed overflow of a+b+cin.
  - It resets to 0 and holds when in_valid=0.
- When undefined: the port does not exist and no extra logic is generated.

Decomposition:
- Shared package rca_pkg holds:
  - RCA_DEFAULT_WIDTH = 4.
  - A typedef for the (WIDTH+1)-bit raw result used by benches for reference-model comparison.
- One sub-module, rca_full_adder (inputs a, b, ci; outputs s, co), is instantiated WIDTH times via a generate loop to form the ripple chain.
- Registers live only in the top level.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after a valid result -> sum=0000, carry=0, out_valid=0 immediately; hold while high.
- Basic adds, WIDTH=4, cin=0, one per cycle:
  - a=0001, b=0001 -> next cycle sum=0010, carry=0.
  - a=0010, b=0001 -> sum=0011, carry=0.
  - a=1000, b=0000 -> sum=1000, carry=0.
- Carry-out / wrap:
  - a=1111, b=0001, cin=0 -> sum=0000, carry=1.
  - a=1111, b=1111, cin=1 -> sum=1111, carry=1.
- Carry-in ripple: a=0111, b=0000, cin=1 -> sum=1000, carry=0. With RCA_SIGNED_OVF_EN, the same stimulus gives overflow=1.
- Valid gating: result 0011 registered, then in_valid=0 with a=1111, b=1111 -> out_valid=0, sum stays 0011, carry stays 0.
- Exhaustive check: all 512 combinations of a, b, cin at WIDTH=4, back-to-back -> every result equals a+b+cin one cycle later; repeat a 1000-vector random sweep at WIDTH=16.
